// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared state, opcode and control-word types for the ctrl_seq sequencer
package ctrl_seq_pkg;
  typedef enum logic [2:0] {T1, T2, T3, WAIT, T4, T5, T6, HALT} state_t;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic mar_load;
    logic ram_out;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic alu_sub;
    logic alu_out;
    logic b_load;
    logic out_load;
    logic halted;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational state + latched opcode -> control word
module ctrl_decode
  import ctrl_seq_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);
  logic is_alu, is_mem;
  assign is_alu = opcode == OP_ADD || opcode == OP_SUB;
  assign is_mem = is_alu || opcode == OP_LDA;
  // one bus driver per state; unknown opcodes fall through as NOP
  always_comb begin
    ctrl = '0;
    case (state)
      T1: begin ctrl.pc_out = 1'b1; ctrl.mar_load = 1'b1; end
      T2: ctrl.pc_inc = 1'b1;
      T3: begin ctrl.ram_out = 1'b1; ctrl.ir_load = 1'b1; end
      T4: begin
        ctrl.ir_out   = is_mem;
        ctrl.mar_load = is_mem;
        ctrl.a_out    = opcode == OP_OUT;
        ctrl.out_load = opcode == OP_OUT;
      end
      T5: begin
        ctrl.ram_out = is_mem;
        ctrl.a_load  = opcode == OP_LDA;
        ctrl.b_load  = is_alu;
      end
      T6: begin
        ctrl.alu_out = is_alu;
        ctrl.a_load  = is_alu;
        ctrl.alu_sub = opcode == OP_SUB;
      end
      HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: microcode sequencer FSM; define CTRL_SEQ_STEP_EN for single-step operation
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int IR_LAT = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_opcode,
  input  logic       step,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       b_load,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] state_dbg
);
  state_t     state, next;
  logic [1:0] cnt;
  logic [3:0] op_q;
  logic       adv, last;
  ctrl_t      ctrl;
  assign last = cnt == 2'(IR_LAT - 1);
`ifdef CTRL_SEQ_STEP_EN
  logic step_q;
  assign adv = step & ~step_q;
  // previous-cycle step, for rising-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) step_q <= 1'b0;
    else step_q <= step;
`else
  logic unused_step;
  assign unused_step = step;
  assign adv = 1'b1;
`endif
  // state register, WAIT counter and opcode latch; all hold unless advancing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= T1;
      cnt   <= '0;
      op_q  <= OP_LDA;
    end else if (adv) begin
      state <= next;
      cnt   <= (state == WAIT && !last) ? cnt + 2'd1 : '0;
      if (state == WAIT && last) op_q <= ir_opcode;
    end
  // next-state sequencing; HALT is only left through rst
  always_comb begin
    next = state;
    case (state)
      T1:      next = T2;
      T2:      next = T3;
      T3:      next = WAIT;
      WAIT:    next = last ? T4 : WAIT;
      T4:      next = op_q == OP_HLT ? HALT : T5;
      T5:      next = T6;
      T6:      next = T1;
      default: next = HALT;
    endcase
  end
  ctrl_decode u_dec (.state(state), .opcode(op_q), .ctrl(ctrl));
  assign {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out, a_load, a_out,
          alu_sub, alu_out, b_load, out_load, halted} = ctrl;
  assign state_dbg = state;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed + randomized checks of ctrl_seq against a cycle-position model
module tb_ctrl_seq;
  localparam int L = 2;
  localparam int N = 6 + L;
  localparam int PI = 12, PO = 11, ML = 10, RO = 9, IL = 8, IO = 7, AL = 6;
  localparam int AO = 5, AS = 4, AU = 3, BL = 2, OL = 1, HL = 0;
  logic clk = 1'b0, rst = 1'b0, step = 1'b0;
  logic [3:0] ir_opcode = 4'h0;
  logic pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out, a_load, a_out;
  logic alu_sub, alu_out, b_load, out_load, halted;
  logic [2:0] state_dbg;
  int checks = 0, passed = 0, fails = 0;
  int p = 0;
  logic [3:0] op_l = 4'h0;
  bit h = 0, sp = 0;
  ctrl_seq #(.IR_LAT(L)) dut (
    .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .step(step),
    .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load), .ram_out(ram_out),
    .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
    .alu_sub(alu_sub), .alu_out(alu_out), .b_load(b_load), .out_load(out_load),
    .halted(halted), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  // expected strobes from position within the instruction (0 = fetch start)
  function automatic logic [12:0] model(int pos, logic [3:0] op, bit hl);
    logic [12:0] v;
    v = '0;
    if (hl) v[HL] = 1'b1;
    else if (pos == 0) begin v[PO] = 1'b1; v[ML] = 1'b1; end
    else if (pos == 1) v[PI] = 1'b1;
    else if (pos == 2) begin v[RO] = 1'b1; v[IL] = 1'b1; end
    else if (pos == L + 3) begin
      if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin v[IO] = 1'b1; v[ML] = 1'b1; end
      else if (op == 4'he) begin v[AO] = 1'b1; v[OL] = 1'b1; end
    end else if (pos == L + 4) begin
      if (op == 4'h0) begin v[RO] = 1'b1; v[AL] = 1'b1; end
      else if (op == 4'h1 || op == 4'h2) begin v[RO] = 1'b1; v[BL] = 1'b1; end
    end else if (pos == L + 5 && (op == 4'h1 || op == 4'h2)) begin
      v[AU] = 1'b1; v[AL] = 1'b1; v[AS] = op == 4'h2;
    end
    return v;
  endfunction
  task automatic check(string tag);
    logic [12:0] e, o;
    e = model(p, op_l, h);
    o = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out, a_load, a_out,
         alu_sub, alu_out, b_load, out_load, halted};
    checks++;
    assert (o === e) passed++;
    else begin fails++; $error("FAIL %s pos=%0d observed=%b expected=%b", tag, p, o, e); end
    checks++;
    assert ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1) passed++;
    else begin fails++; $error("FAIL %s_bus observed=%b expected=at most one driver", tag,
                               {pc_out, ram_out, ir_out, a_out, alu_out}); end
  endtask
  // apply model's view of one clock edge, then sample after it
  task automatic tick(string tag);
    bit adv;
`ifdef CTRL_SEQ_STEP_EN
    adv = step && !sp;
`else
    adv = 1;
`endif
    sp = step;
    if (adv && !h) begin
      if (p == L + 3 && op_l == 4'hf) h = 1;
      else begin
        if (p == L + 2) op_l = ir_opcode;
        p = (p + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    check(tag);
  endtask
  task automatic do_reset(string tag);
    #2 rst = 1'b1;
    #1;
    p = 0; op_l = 4'h0; h = 0; sp = 0;
    check({tag, "_async"});
    @(posedge clk);
    #1;
    check({tag, "_hold"});
    rst = 1'b0;
  endtask
  initial begin
    #1 rst = 1'b1;
    #1 check("reset_async");
    @(posedge clk);
    #1 check("reset_hold");
    rst = 1'b0;
`ifdef CTRL_SEQ_STEP_EN
    step = 1'b1;
    repeat (10) tick("step_held");
    step = 1'b0;
    repeat (3) tick("step_low");
    repeat (3) begin
      step = 1'b1; tick("step_pulse");
      step = 1'b0; tick("step_gap");
    end
    do_reset("step_rst");
    repeat (400) begin
      step = 1'($urandom_range(0, 1));
      ir_opcode = 4'($urandom_range(0, 15));
      tick("step_rand");
      if (h && $urandom_range(0, 3) == 0) do_reset("step_rand_rst");
    end
`else
    ir_opcode = 4'h0;
    repeat (2 * N) tick("lda");
    ir_opcode = 4'h2;
    repeat (N) tick("sub");
    ir_opcode = 4'h1;
    repeat (L + 3) tick("add_pre");
    ir_opcode = 4'he;
    repeat (N) tick("add_switch");
    ir_opcode = 4'h1;
    for (int i = 0; i < 2 * N && !(p == L + 4 && op_l == 4'h1); i++) tick("add_to_t5");
    do_reset("rst_mid");
    ir_opcode = 4'hf;
    repeat (L + 4) tick("hlt");
    repeat (20) tick("halt_hold");
    do_reset("rst_halt");
    repeat (400) begin
      ir_opcode = 4'($urandom_range(0, 15));
      tick("rand");
      if ((h && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) do_reset("rand_rst");
    end
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter: IR_LAT, default 2, cycles from the IR load edge until ir_opcode is valid; legal range 1..3.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ir_opcode  input  4  opcode nibble from the instruction register output.
REQ-005 step  input  1  single-step request, synchronous to clk; used only with CTRL_SEQ_STEP_EN defined.
REQ-006 pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out  output  1 each  control strobes, active-high.
REQ-007 a_load, a_out, alu_sub, alu_out, b_load, out_load  output  1 each  control strobes, active-high.
REQ-008 halted  output  1  high while in HALT.
REQ-009 state_dbg  output  3  current state encoding, for debug.

Function
REQ-010 States: T1, T2, T3, WAIT, T4, T5, T6, HALT.
REQ-011 Transitions: T1->T2->T3->WAIT; WAIT held IR_LAT cycles (internal counter) ->T4->T5->T6->T1; HLT at T4 ->HALT.
REQ-012 Opcode latched into internal register on the final WAIT cycle edge; all T4-T6 decoding uses the latched opcode only.
REQ-013 Control outputs: Moore decode of state and latched opcode; no combinational path from inputs to outputs.
REQ-014 T1: pc_out, mar_load. T2: pc_inc. T3: ram_out, ir_load. WAIT: all strobes low.
REQ-015 LDA (0000): T4 ir_out, mar_load; T5 ram_out, a_load; T6 none.
REQ-016 ADD (0001): T4 ir_out, mar_load; T5 ram_out, b_load; T6 alu_out, a_load, alu_sub=0.
REQ-017 SUB (0010): as ADD, with alu_sub=1 in T6 only.
REQ-018 OUT (1110): T4 a_out, out_load; T5, T6 none.
REQ-019 HLT (1111): T4 all strobes low; next state HALT instead of T5.
REQ-020 Any other opcode: NOP; T4-T6 all strobes low; sequence continues to T1.
REQ-021 HALT: all strobes low, halted=1; left only by rst.
REQ-022 No two of {pc_out, ram_out, ir_out, a_out, alu_out} high in the same cycle (single bus driver).
REQ-023 Instruction length: 6+IR_LAT cycles; HLT: 4+IR_LAT cycles to HALT.

Reset
REQ-024 rst high: state=T1, WAIT counter=0, latched opcode=4'b0000, step edge detector cleared, immediately and regardless of clk.
REQ-025 During and after reset until the first advance, outputs = T1 decode (pc_out=1, mar_load=1, all others 0, halted=0).
REQ-026 rst asserted mid-instruction or in HALT aborts and restarts at T1; no partial-state retention.

Configuration
REQ-027 Macro CTRL_SEQ_STEP_EN defined: state advances only on a cycle where step rose (step=1, previous-cycle step=0); otherwise state, counter and outputs hold.
REQ-028 Step mode: each rising step edge advances exactly one state (one WAIT count); step held high advances once.
REQ-029 Macro undefined: step ignored, state advances every cycle; port still present.

Structure
REQ-030 Shared package ctrl_seq_pkg: state enum, opcode constants (LDA, ADD, SUB, OUT, HLT), control-word struct type.
REQ-031 One sub-module ctrl_decode: purely combinational state+opcode -> control word.
REQ-032 FSM, WAIT counter, opcode latch and step edge detector reside in ctrl_seq.

Verification
REQ-033 Reset then free run, ir_opcode=0000, IR_LAT=2 -> T1..T3, 2 WAIT, T4..T6; a_load only in T5; period 8 cycles.
REQ-034 ir_opcode=0010 (SUB) -> T6 shows alu_out=1, a_load=1, alu_sub=1; alu_sub=0 in every other cycle.
REQ-035 ir_opcode=1111 -> T4 all strobes 0, then halted=1 held for 20 cycles; rst pulse -> T1, halted=0.
REQ-036 ir_opcode switched 0001->1110 in the cycle after the opcode latch edge -> T5/T6 still decode ADD (b_load in T5).
REQ-037 rst asserted mid-cycle in T5 of ADD -> outputs = T1 decode before next clk edge.
REQ-038 CTRL_SEQ_STEP_EN defined, step held high 10 cycles then low -> exactly one advance (T1->T2); three 1-cycle pulses -> T2->T3->WAIT->WAIT.
